// File: rtl/mario_sprite_compositor.sv
// Sprite address generator and colour compositor sitting between the VGA
// scan counters and the Mario / platform-block sprite ROMs. Addresses are
// combinational from the scan position; the hit flags and pixel-valid are
// delayed one cycle to line up with the ROM read latency, then the final
// colour is chosen (chroma key, layer priority) into a registered output.
module mario_sprite_compositor #(
  parameter logic [9:0]  MARIO_X0    = 10'd100,
  parameter logic [9:0]  MARIO_Y0    = 10'd400,
  parameter logic [9:0]  PLATFORM_Y  = 10'd416,
  parameter logic [23:0] TRANSPARENT = 24'hFF00FF,
  parameter logic [23:0] SKY         = 24'h5C94FC
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        pixel_valid,
  input  logic        frame_start,
  input  logic [9:0]  MarioX,
  input  logic [9:0]  MarioY,
  input  logic        mario_left,
  output logic [7:0]  mario_addr,
  input  logic [23:0] mario_data,
  output logic [7:0]  block_addr,
  input  logic [23:0] block_data,
  output logic [7:0]  Red,
  output logic [7:0]  Green,
  output logic [7:0]  Blue,
  output logic        pixel_out_valid
);

  // Returns {valid, rgb}: blanking beats Mario, Mario beats the block, and
  // a chroma-keyed texel falls through to the next layer down.
  function automatic logic [24:0] pick_colour(
    input logic        vld,
    input logic        m_hit,
    input logic        b_hit,
    input logic [23:0] m_texel,
    input logic [23:0] b_texel
  );
    if (!vld)
      pick_colour = 25'd0;
    else if (m_hit && (m_texel != TRANSPARENT))
      pick_colour = {1'b1, m_texel};
    else if (b_hit && (b_texel != TRANSPARENT))
      pick_colour = {1'b1, b_texel};
    else
      pick_colour = {1'b1, SKY};
  endfunction

  logic [9:0]  lx_q, lx_d, ly_q, ly_d;
  logic        ll_q, ll_d;
  logic        m_hit_d, b_hit_d, vld_d;
  logic        m_hit_q, b_hit_q, vld_q;
  logic [10:0] lx_end, ly_end, py_end;
  logic [3:0]  dx_lo, dy_lo, by_lo, col;
  logic [23:0] rgb_d, rgb_q;
  logic        pov_d, pov_q;

  // Position latch: only updated at frame start so a frame never tears.
  always_comb begin
    lx_d = lx_q;
    ly_d = ly_q;
    ll_d = ll_q;
    if (frame_start) begin
      lx_d = MarioX;
      ly_d = MarioY;
      ll_d = mario_left;
    end
  end

  // Latch registers; reset wins over a coincident frame_start.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      lx_q <= MARIO_X0;
      ly_q <= MARIO_Y0;
      ll_q <= 1'b0;
    end else begin
      lx_q <= lx_d;
      ly_q <= ly_d;
      ll_q <= ll_d;
    end
  end

  // Stage A: hit tests and ROM addresses from the scan position.
  // Bounds are widened to 11 bits so a sprite near column/row 1023 cannot
  // wrap around and hit near 0. Only the low nibble of each difference
  // reaches the address, so the subtractions are done at 4 bits.
  always_comb begin
    lx_end  = {1'b0, lx_q} + 11'd16;
    ly_end  = {1'b0, ly_q} + 11'd16;
    py_end  = {1'b0, PLATFORM_Y} + 11'd16;
    m_hit_d = (DrawX >= lx_q) && ({1'b0, DrawX} < lx_end) &&
              (DrawY >= ly_q) && ({1'b0, DrawY} < ly_end);
    b_hit_d = (DrawY >= PLATFORM_Y) && ({1'b0, DrawY} < py_end);
    vld_d   = pixel_valid;
    dx_lo   = DrawX[3:0] - lx_q[3:0];
    dy_lo   = DrawY[3:0] - ly_q[3:0];
    by_lo   = DrawY[3:0] - PLATFORM_Y[3:0];
    col     = ll_q ? (4'd15 - dx_lo) : dx_lo;
    mario_addr = m_hit_d ? {dy_lo, col} : 8'd0;
    block_addr = b_hit_d ? {by_lo, DrawX[3:0]} : 8'd0;
  end

  // Stage B: hold the hit flags while the ROMs produce their texels.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      m_hit_q <= 1'b0;
      b_hit_q <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      m_hit_q <= m_hit_d;
      b_hit_q <= b_hit_d;
      vld_q   <= vld_d;
    end
  end

  // Stage C colour selection against the now-valid ROM data.
  always_comb begin
    {pov_d, rgb_d} = pick_colour(vld_q, m_hit_q, b_hit_q, mario_data, block_data);
  end

  // Stage C: registered colour to the VGA output.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rgb_q <= 24'd0;
      pov_q <= 1'b0;
    end else begin
      rgb_q <= rgb_d;
      pov_q <= pov_d;
    end
  end

  assign Red             = rgb_q[23:16];
  assign Green           = rgb_q[15:8];
  assign Blue            = rgb_q[7:0];
  assign pixel_out_valid = pov_q;

endmodule

// File: tb/tb_mario_sprite_compositor.sv
// Scoreboard bench for mario_sprite_compositor with registered ROM models.
module tb_mario_sprite_compositor;

  localparam logic [23:0] TR    = 24'hFF00FF;
  localparam logic [23:0] SKY_C = 24'h5C94FC;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [9:0]  DrawX = '0, DrawY = '0, MarioX = '0, MarioY = '0;
  logic        pixel_valid = 1'b0, frame_start = 1'b0, mario_left = 1'b0;
  logic [7:0]  mario_addr, block_addr;
  logic [23:0] mario_data = '0, block_data = '0;
  logic [7:0]  Red, Green, Blue;
  logic        pixel_out_valid;

  logic [23:0] mario_rom [256];
  logic [23:0] block_rom [256];

  int n_vec = 0;
  int n_err = 0;
  logic [24:0] sb [$];
  int m_lx = 100;
  int m_ly = 400;
  bit m_ll = 1'b0;

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    mario_data <= mario_rom[mario_addr];
    block_data <= block_rom[block_addr];
  end

  mario_sprite_compositor dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
    .pixel_valid(pixel_valid), .frame_start(frame_start),
    .MarioX(MarioX), .MarioY(MarioY), .mario_left(mario_left),
    .mario_addr(mario_addr), .mario_data(mario_data),
    .block_addr(block_addr), .block_data(block_data),
    .Red(Red), .Green(Green), .Blue(Blue), .pixel_out_valid(pixel_out_valid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle of stimulus; checks addresses now, output two cycles on.
  task automatic step(input int x, input int y, input bit pv, input bit fs,
                      input bit rst, input int mx, input int my, input bit ml);
    logic [24:0] e;
    bit mh, bh;
    int ea, eb;
    @(negedge Clk);
    if (sb.size() >= 2) begin
      e = sb.pop_front();
      chk("pix_out", {7'd0, pixel_out_valid, Red, Green, Blue}, {7'd0, e});
    end
    DrawX = 10'(x); DrawY = 10'(y); pixel_valid = pv; frame_start = fs;
    Reset = rst; MarioX = 10'(mx); MarioY = 10'(my); mario_left = ml;
    #1;
    mh = (x >= m_lx) && (x < m_lx + 16) && (y >= m_ly) && (y < m_ly + 16);
    ea = mh ? ((y - m_ly) * 16 + (m_ll ? 15 - (x - m_lx) : (x - m_lx))) : 0;
    bh = (y >= 416) && (y < 432);
    eb = bh ? ((y - 416) * 16 + (x % 16)) : 0;
    chk("mario_addr", {24'd0, mario_addr}, 32'(ea));
    chk("block_addr", {24'd0, block_addr}, 32'(eb));
    if (!pv) e = 25'd0;
    else if (mh && mario_rom[ea] != TR) e = {1'b1, mario_rom[ea]};
    else if (bh && block_rom[eb] != TR) e = {1'b1, block_rom[eb]};
    else e = {1'b1, SKY_C};
    sb.push_back(e);
    if (rst) begin
      foreach (sb[i]) sb[i] = 25'd0;
      m_lx = 100; m_ly = 400; m_ll = 1'b0;
    end else if (fs) begin
      m_lx = mx; m_ly = my; m_ll = ml;
    end
  endtask

  task automatic pix(input int x, input int y);
    step(x, y, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic latch(input int mx, input int my, input bit ml);
    step(0, 0, 1'b0, 1'b1, 1'b0, mx, my, ml);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mario_rom[i] = {8'(i), ~8'(i), 8'h3C};
      block_rom[i] = {8'h80, 8'(i), 8'h10};
    end
    mario_rom[8'h53] = 24'h112233;
    mario_rom[8'h5C] = 24'h445566;
    for (int i = 8'hA0; i <= 8'hAF; i++) mario_rom[i] = TR;
    for (int i = 8'h40; i <= 8'h47; i++) block_rom[i] = 24'hA0522D;
    for (int i = 8'h48; i <= 8'h4F; i++) block_rom[i] = TR;

    // reset
    for (int i = 0; i < 3; i++) step(0, 0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
    chk("rst_out", {7'd0, pixel_out_valid, Red, Green, Blue}, 32'd0);

    // sky row
    for (int i = 0; i < 4; i++) pix(i * 37, 0);

    // latch and hit, then mirrored
    latch(100, 200, 1'b0);
    pix(103, 205);
    chk("hit_addr", {24'd0, mario_addr}, 32'h53);
    latch(100, 200, 1'b1);
    pix(103, 205);
    chk("mirror_addr", {24'd0, mario_addr}, 32'h5C);

    // transparency and priority over the platform
    latch(100, 410, 1'b0);
    for (int x = 98; x < 114; x++) pix(x, 420);

    // wrap guard and unlatched inputs
    latch(1020, 0, 1'b0);
    pix(2, 5);
    chk("wrap_addr", {24'd0, mario_addr}, 32'd0);
    for (int x = 1018; x < 1024; x++) pix(x, 3);
    step(1021, 3, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1);
    step(5, 3, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1);

    // blanking
    for (int i = 0; i < 3; i++) step(1021, 3, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);

    // reset mid-stream during a Mario hit
    latch(100, 200, 1'b0);
    pix(103, 205);
    step(104, 205, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0);
    pix(103, 205);
    chk("rst_latch_miss", {24'd0, mario_addr}, 32'd0);
    pix(103, 405);
    chk("rst_latch_hit", {24'd0, mario_addr}, 32'h53);

    // reset and frame_start together
    step(0, 0, 1'b0, 1'b1, 1'b1, 300, 300, 1'b1);
    pix(103, 405);

    // frame_start with a visible pixel uses the old latch that cycle
    step(103, 405, 1'b1, 1'b1, 1'b0, 110, 420, 1'b1);
    pix(112, 425);

    // random sweep
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0)
        step($urandom_range(90, 130), $urandom_range(395, 440), 1'b1, 1'b1, 1'b0,
             ($urandom_range(0, 7) == 0) ? $urandom_range(1010, 1023) : $urandom_range(85, 120),
             $urandom_range(395, 425), 1'($urandom_range(0, 1)));
      else
        step($urandom_range(85, 135), $urandom_range(395, 440),
             1'($urandom_range(0, 9) != 0), 1'b0, 1'b0, 0, 0, 1'b0);
    end

    // drain the pipeline
    for (int i = 0; i < 3; i++) step(0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
